// File: rtl/load_ext_unit_pkg.sv
// Shared definitions for the MEM-stage load path: opcode constants, FSM
// states and small decode helpers.
package load_ext_unit_pkg;

  // Load / store major opcodes (instr[31:26]).
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } ld_state_e;

  function automatic logic is_load_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
           (op == OP_LB) || (op == OP_LBU);
  endfunction

  // Word loads need a word-aligned address, halfword loads an even one.
  function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] lo);
    return ((op == OP_LW) && (lo != 2'b00)) ||
           (((op == OP_LH) || (op == OP_LHU)) && lo[0]);
  endfunction

endpackage

// File: rtl/load_ext_unit_if.sv
// Pipeline + data-memory signals of the load unit.
// Handshake: a request is taken when req_valid=1, the op is an aligned load,
// flush=0 and the unit is idle and not draining; ld_stall is high in that
// cycle and until the response arrives. mem_rd_en is a single-cycle strobe
// with no ready; memory answers later with a one-cycle mem_rvalid.
// ld_valid / ld_misalign / ld_buserr are one-cycle completion pulses.
interface load_ext_unit_if;
  logic        flush;
  logic        req_valid;
  logic [5:0]  req_op;
  logic [31:0] req_addr;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        ld_stall;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_misalign;
  logic        ld_buserr;

  modport slave (
    input  flush, req_valid, req_op, req_addr, mem_rvalid, mem_rdata,
    output mem_rd_en, mem_addr, ld_stall, ld_valid, ld_data, ld_misalign, ld_buserr
  );

  modport master (
    output flush, req_valid, req_op, req_addr, mem_rvalid, mem_rdata,
    input  mem_rd_en, mem_addr, ld_stall, ld_valid, ld_data, ld_misalign, ld_buserr
  );
endinterface

// File: rtl/load_ext_unit_extract.sv
// Combinational byte/halfword select and sign/zero extension of a read word.
// Also used by the forwarding logic, so it carries no state.
module load_ext_unit_extract
  import load_ext_unit_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane, then extend according to the load flavour.
  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  data = {24'h000000, byte_sel};
      OP_LH:   data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  data = {16'h0000, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_ext_unit.sv
// MEM-stage load unit: accepts a load, strobes one word read, waits for a
// variable-latency response (bounded by TIMEOUT_CYCLES) and returns the
// extended result. Flush/timeout leave a drain flag so the orphaned response
// of an abandoned read is swallowed.
module load_ext_unit
  import load_ext_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  load_ext_unit_if.slave   bus,
  output ld_state_e        dbg_state
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  ld_state_e   state;
  logic [5:0]  op_q;
  logic [1:0]  lo_q;
  logic        drain;
  logic [CW-1:0] cnt;
  logic [31:0] ext_data;
  logic        is_ld;
  logic        misal;
  logic        accept;
  logic        tmo;

  load_ext_unit_extract u_extract (
    .op      (op_q),
    .addr_lo (lo_q),
    .rdata   (bus.mem_rdata),
    .data    (ext_data)
  );

  // Request decode, acceptance and timeout detection.
  always_comb begin
    is_ld  = is_load_op(bus.req_op);
    misal  = is_misaligned(bus.req_op, bus.req_addr[1:0]);
    accept = (state == ST_IDLE) && bus.req_valid && is_ld && !misal &&
             !bus.flush && !drain;
    tmo    = (TIMEOUT_CYCLES != 0) && (cnt == CW'(TIMEOUT_CYCLES - 1));
  end

  // Stall covers the acceptance cycle and the whole wait; a flush in DONE
  // squashes the result pulse.
  assign bus.ld_stall = accept || (state == ST_WAIT);
  assign bus.ld_valid = (state == ST_DONE) && !bus.flush;
  assign dbg_state    = state;

  // Load FSM with registered memory strobe, result and exception pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      op_q            <= '0;
      lo_q            <= '0;
      drain           <= 1'b0;
      cnt             <= '0;
      bus.mem_rd_en   <= 1'b0;
      bus.mem_addr    <= '0;
      bus.ld_data     <= '0;
      bus.ld_misalign <= 1'b0;
      bus.ld_buserr   <= 1'b0;
    end else begin
      bus.mem_rd_en   <= 1'b0;
      bus.ld_misalign <= 1'b0;
      bus.ld_buserr   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (drain && bus.mem_rvalid) drain <= 1'b0;
          if (accept) begin
            state         <= ST_WAIT;
            bus.mem_rd_en <= 1'b1;
            bus.mem_addr  <= {bus.req_addr[31:2], 2'b00};
            op_q          <= bus.req_op;
            lo_q          <= bus.req_addr[1:0];
            cnt           <= '0;
          end else if (bus.req_valid && is_ld && misal && !bus.flush) begin
            bus.ld_misalign <= 1'b1;
          end
        end
        ST_WAIT: begin
          cnt <= cnt + CW'(1);
          if (bus.mem_rvalid) begin
            // A response coinciding with a flush belongs to the flushed load.
            if (bus.flush) begin
              state <= ST_IDLE;
            end else begin
              bus.ld_data <= ext_data;
              state       <= ST_DONE;
            end
          end else if (bus.flush) begin
            state <= ST_IDLE;
            drain <= 1'b1;
          end else if (tmo) begin
            bus.ld_buserr <= 1'b1;
            drain         <= 1'b1;
            state         <= ST_IDLE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_ext_unit.sv
// Bench for load_ext_unit (TIMEOUT_CYCLES=4): directed scenarios plus random
// loads checked against an arithmetic reference of the load semantics.
module tb_load_ext_unit;
  import load_ext_unit_pkg::*;

  logic      clk;
  logic      rst;
  ld_state_e dbg_state;
  int        checks;
  int        failures;
  logic [31:0] last_data;
  bit        hold_known;
  logic [5:0] load_ops [5];

  load_ext_unit_if bus ();

  load_ext_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush      = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_op     = 6'($urandom);
    bus.req_addr   = $urandom;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = $urandom;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_load(input logic [5:0] op, input logic [31:0] addr,
                                           input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * addr[1:0])) & 32'h0000_00FF;
    h = (w >> (16 * addr[1])) & 32'h0000_FFFF;
    case (op)
      6'b100000: return (b >= 32'd128)   ? b - 32'd256   : b;
      6'b100100: return b;
      6'b100001: return (h >= 32'd32768) ? h - 32'd65536 : h;
      6'b100101: return h;
      default:   return w;
    endcase
  endfunction

  // ---------------- driver: one complete load ----------------
  // rvalid arrives lat cycles after the rd_en cycle.
  task automatic do_load(input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] w, input int lat);
    logic [31:0] exp_q[$];
    logic [31:0] exp_d;
    exp_q.push_back(ref_load(op, addr, w));
    bus.req_valid  = 1'b1;
    bus.req_op     = op;
    bus.req_addr   = addr;
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.ld_stall, bus.ld_valid, bus.mem_rd_en} !== 3'b100) begin
      failures++;
      $display("FAIL accept_ctl op=%b addr=%h got=%b exp=100", op, addr,
               {bus.ld_stall, bus.ld_valid, bus.mem_rd_en});
    end
    if (hold_known) begin
      checks++;
      if (bus.ld_data !== last_data) begin
        failures++;
        $display("FAIL data_hold got=%h exp=%h", bus.ld_data, last_data);
      end
    end
    tick();
    bus.req_valid = 1'b0;
    bus.req_op    = 6'($urandom);
    bus.req_addr  = $urandom;
    for (int k = 0; k <= lat; k++) begin
      bus.mem_rvalid = (k == lat);
      bus.mem_rdata  = (k == lat) ? w : $urandom;
      @(negedge clk);
      checks++;
      if ({bus.ld_stall, bus.ld_valid, bus.mem_rd_en, bus.ld_buserr} !==
          {1'b1, 1'b0, (k == 0), 1'b0}) begin
        failures++;
        $display("FAIL wait_ctl k=%0d got=%b exp=%b", k,
                 {bus.ld_stall, bus.ld_valid, bus.mem_rd_en, bus.ld_buserr},
                 {1'b1, 1'b0, (k == 0), 1'b0});
      end
      checks++;
      if (bus.mem_addr !== (addr & 32'hFFFF_FFFC)) begin
        failures++;
        $display("FAIL mem_addr got=%h exp=%h", bus.mem_addr, addr & 32'hFFFF_FFFC);
      end
      tick();
    end
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = $urandom;
    exp_d = exp_q.pop_front();
    @(negedge clk);
    checks++;
    if ({bus.ld_stall, bus.ld_valid, bus.mem_rd_en} !== 3'b010) begin
      failures++;
      $display("FAIL done_ctl got=%b exp=010", {bus.ld_stall, bus.ld_valid, bus.mem_rd_en});
    end
    checks++;
    if (bus.ld_data !== exp_d) begin
      failures++;
      $display("FAIL ld_data op=%b addr=%h rdata=%h got=%h exp=%h", op, addr, w,
               bus.ld_data, exp_d);
    end
    tick();
    last_data  = exp_d;
    hold_known = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if ({bus.mem_rd_en, bus.ld_stall, bus.ld_valid, bus.ld_misalign, bus.ld_buserr} !== 5'b0 ||
        bus.mem_addr !== 32'h0 || bus.ld_data !== 32'h0 || dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_state ctl=%b addr=%h data=%h st=%0d exp=all zero",
               {bus.mem_rd_en, bus.ld_stall, bus.ld_valid, bus.ld_misalign, bus.ld_buserr},
               bus.mem_addr, bus.ld_data, dbg_state);
    end
    tick();
    rst = 1'b0;
    last_data  = 32'h0;
    hold_known = 1'b1;
  endtask

  task automatic test_lw_basic();
    do_load(OP_LW, 32'h0000_0100, 32'hDEAD_BEEF, 2);
  endtask

  task automatic test_extract();
    do_load(OP_LB,  32'h0000_0203, 32'h80FF_7F01, 1);
    do_load(OP_LBU, 32'h0000_0203, 32'h80FF_7F01, 0);
    do_load(OP_LH,  32'h0000_0202, 32'h80FF_7F01, 3);
    do_load(OP_LHU, 32'h0000_0200, 32'h80FF_7F01, 2);
    do_load(OP_LB,  32'h0000_0201, 32'h80FF_7F01, 1);
  endtask

  task automatic test_misalign();
    logic [5:0]  mops  [4];
    logic [31:0] maddr [4];
    mops  = '{OP_LW, OP_LH, OP_LHU, OP_LW};
    maddr = '{32'h102, 32'h101, 32'h103, 32'h101};
    for (int i = 0; i < 4; i++) begin
      bus.req_valid = 1'b1;
      bus.req_op    = mops[i];
      bus.req_addr  = maddr[i];
      @(negedge clk);
      checks++;
      if ({bus.ld_stall, bus.ld_misalign} !== 2'b00) begin
        failures++;
        $display("FAIL misalign_present i=%0d got=%b exp=00", i, {bus.ld_stall, bus.ld_misalign});
      end
      tick();
      idle_inputs();
      @(negedge clk);
      checks++;
      if ({bus.ld_misalign, bus.mem_rd_en, bus.ld_stall} !== 3'b100) begin
        failures++;
        $display("FAIL misalign_pulse i=%0d got=%b exp=100", i,
                 {bus.ld_misalign, bus.mem_rd_en, bus.ld_stall});
      end
      tick();
      @(negedge clk);
      checks++;
      if ({bus.ld_misalign, bus.mem_rd_en} !== 2'b00) begin
        failures++;
        $display("FAIL misalign_end i=%0d got=%b exp=00", i, {bus.ld_misalign, bus.mem_rd_en});
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    bus.req_valid = 1'b1;
    bus.req_op    = OP_LW;
    bus.req_addr  = 32'h0000_0400;
    tick();
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.ld_stall, bus.mem_rd_en, bus.ld_buserr} !== {1'b1, (k == 0), 1'b0}) begin
        failures++;
        $display("FAIL timeout_wait k=%0d got=%b exp=%b", k,
                 {bus.ld_stall, bus.mem_rd_en, bus.ld_buserr}, {1'b1, (k == 0), 1'b0});
      end
      tick();
    end
    // Present a new load while draining: it must not be taken.
    bus.req_valid = 1'b1;
    bus.req_op    = OP_LW;
    bus.req_addr  = 32'h0000_0500;
    @(negedge clk);
    checks++;
    if ({bus.ld_buserr, bus.ld_stall, bus.ld_valid} !== 3'b100) begin
      failures++;
      $display("FAIL timeout_pulse got=%b exp=100", {bus.ld_buserr, bus.ld_stall, bus.ld_valid});
    end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if ({bus.mem_rd_en, bus.ld_buserr} !== 2'b00) begin
      failures++;
      $display("FAIL drain_block got=%b exp=00", {bus.mem_rd_en, bus.ld_buserr});
    end
    tick();
    bus.mem_rvalid = 1'b1;
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if ({bus.ld_valid, bus.ld_stall} !== 2'b00) begin
      failures++;
      $display("FAIL late_rvalid got=%b exp=00", {bus.ld_valid, bus.ld_stall});
    end
    tick();
    do_load(OP_LW, 32'h0000_0500, 32'h1234_5678, 1);
  endtask

  task automatic test_flush();
    bus.req_valid = 1'b1;
    bus.req_op    = OP_LW;
    bus.req_addr  = 32'h0000_0600;
    tick();
    idle_inputs();
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.ld_stall, bus.ld_valid} !== 2'b00) begin
      failures++;
      $display("FAIL flush_idle got=%b exp=00", {bus.ld_stall, bus.ld_valid});
    end
    tick();
    tick();
    bus.mem_rvalid = 1'b1;
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (bus.ld_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_stale got=%b exp=0", bus.ld_valid);
    end
    tick();
    do_load(OP_LHU, 32'h0000_0702, 32'hCAFE_F00D, 2);
  endtask

  task automatic test_flush_done();
    bus.req_valid = 1'b1;
    bus.req_op    = OP_LW;
    bus.req_addr  = 32'h0000_0800;
    tick();
    idle_inputs();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h5555_AAAA;
    tick();
    idle_inputs();
    bus.flush = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.ld_valid, bus.ld_stall} !== 2'b00) begin
      failures++;
      $display("FAIL flush_done got=%b exp=00", {bus.ld_valid, bus.ld_stall});
    end
    tick();
    bus.flush = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.ld_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_done_after got=%b exp=0", bus.ld_valid);
    end
    tick();
    hold_known = 1'b0;
    do_load(OP_LB, 32'h0000_0900, 32'h0000_00F0, 1);
  endtask

  task automatic test_reset_wait();
    bus.req_valid = 1'b1;
    bus.req_op    = OP_LW;
    bus.req_addr  = 32'h0000_0A00;
    tick();
    idle_inputs();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.mem_rd_en, bus.ld_stall, bus.ld_valid, bus.ld_misalign, bus.ld_buserr} !== 5'b0 ||
        bus.mem_addr !== 32'h0 || bus.ld_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_wait ctl=%b addr=%h data=%h exp=all zero",
               {bus.mem_rd_en, bus.ld_stall, bus.ld_valid, bus.ld_misalign, bus.ld_buserr},
               bus.mem_addr, bus.ld_data);
    end
    tick();
    bus.mem_rvalid = 1'b1;
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if ({bus.ld_valid, bus.ld_stall} !== 2'b00) begin
      failures++;
      $display("FAIL reset_stray got=%b exp=00", {bus.ld_valid, bus.ld_stall});
    end
    tick();
    last_data  = 32'h0;
    hold_known = 1'b1;
    do_load(OP_LH, 32'h0000_0B02, 32'h7FFF_8001, 0);
  endtask

  task automatic test_random();
    logic [5:0]  op;
    logic [31:0] addr;
    for (int n = 0; n < 40; n++) begin
      op   = load_ops[$urandom_range(0, 4)];
      addr = $urandom;
      if (op == OP_LW) addr[1:0] = 2'b00;
      if (op == OP_LH || op == OP_LHU) addr[0] = 1'b0;
      case ($urandom_range(0, 3))
        0: begin
          // Non-load op with req_valid: must be ignored.
          do op = 6'($urandom); while (op inside {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU});
          bus.req_valid = 1'b1;
          bus.req_op    = op;
          @(negedge clk);
          checks++;
          if (bus.ld_stall !== 1'b0) begin
            failures++;
            $display("FAIL nonload_stall op=%b got=%b exp=0", op, bus.ld_stall);
          end
          tick();
          idle_inputs();
          @(negedge clk);
          checks++;
          if ({bus.mem_rd_en, bus.ld_misalign} !== 2'b00) begin
            failures++;
            $display("FAIL nonload_rd op=%b got=%b exp=00", op, {bus.mem_rd_en, bus.ld_misalign});
          end
          tick();
        end
        1: begin
          // Stray rvalid while idle and not draining: ignored.
          bus.mem_rvalid = 1'b1;
          tick();
          idle_inputs();
          @(negedge clk);
          checks++;
          if (bus.ld_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_rvalid got=%b exp=0", bus.ld_valid);
          end
          tick();
        end
        default: do_load(op, addr, $urandom, $urandom_range(0, 3));
      endcase
    end
  endtask

  task automatic test_back_to_back();
    do_load(OP_LBU, 32'h0000_0C01, 32'h00AB_0000 | 32'h0000_CD00, 0);
    do_load(OP_LW,  32'h0000_0C04, 32'h0BAD_F00D, 0);
    do_load(OP_LH,  32'h0000_0C06, 32'h9000_0001, 3);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    last_data  = 32'h0;
    hold_known = 1'b0;
    load_ops   = '{OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU};
    rst        = 1'b1;
    idle_inputs();
    test_reset();
    test_lw_basic();
    test_extract();
    test_misalign();
    test_timeout();
    test_flush();
    test_flush_done();
    test_reset_wait();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
